// File: rtl/hsbus_ram_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : HSBus_Pkg
//  Description : Shared types and helpers for the hsbus RAM responder:
//                store-width encoding, byte-enable generation, store
//                alignment check, lane replication and byte-mask expansion.
//                Load FSM state encodings also live here.
//                Optional feature macro used by the design: HSRAM_STORE_BUFFER_EN
//  Revision    : 1.0 - initial release
// ============================================================================
package HSBus_Pkg;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'b00,
        WIDTH_HALF = 2'b01,
        WIDTH_WORD = 2'b10,
        WIDTH_RSVD = 2'b11
    } hs_width_e;

    // Load FSM. RPEND is the extra issue cycle used when a store must take
    // the array port (or free the store buffer) before the load can read.
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RPEND = 2'd1;
    localparam logic [1:0] c_ST_RDATA = 2'd2;

    function automatic logic [3:0] hs_byte_en(input hs_width_e w, input logic [1:0] a);
        case (w)
            WIDTH_BYTE: return 4'b0001 << a;
            WIDTH_HALF: return a[1] ? 4'b1100 : 4'b0011;
            WIDTH_WORD: return 4'b1111;
            default:    return 4'b0000;
        endcase
    endfunction

    // Reserved width counts as misaligned so a single check rejects both.
    function automatic logic hs_misaligned(input hs_width_e w, input logic [1:0] a);
        case (w)
            WIDTH_BYTE: return 1'b0;
            WIDTH_HALF: return a[0];
            WIDTH_WORD: return |a;
            default:    return 1'b1;
        endcase
    endfunction

    // Store data arrives right-justified; replicate it onto every lane so the
    // byte enables alone pick the destination.
    function automatic logic [31:0] hs_lane_data(input hs_width_e w, input logic [31:0] d);
        case (w)
            WIDTH_BYTE: return {4{d[7:0]}};
            WIDTH_HALF: return {2{d[15:0]}};
            default:    return d;
        endcase
    endfunction

    function automatic logic [31:0] hs_be_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/hsbus_ram_responder_array.sv
`default_nettype none
// ============================================================================
//  Module      : HSRAM_Array
//  Description : Single-port, byte-enabled 32-bit word array with registered
//                read. One access per cycle; read has priority if both
//                enables are raised. Contents are never reset; only the
//                read register is.
//  Ports       : clk, rst_sync_n (sync, active-low)
//                rd_en_i / wr_en_i   - access strobes
//                idx_i [AW-1:0]      - word index shared by read and write
//                wbe_i [3:0]         - write byte enables
//                wdata_i / rdata_o   - write data / registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module HSRAM_Array #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst_sync_n,
    input  logic          rd_en_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] idx_i,
    input  logic [3:0]    wbe_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (wr_en_i && !rd_en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (wbe_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Holds its value when no read is issued, which keeps load data stable
    // while the core is stalled.
    always_ff @(posedge clk) begin
        if (!rst_sync_n) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/hsbus_ram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : hsbus_ram_responder
//  Description : Core-side RAM responder. Loads take one stall cycle
//                (registered array read); stores complete without stall.
//                Out-of-range or misaligned accesses pulse bus_err; bad
//                stores write nothing, bad loads return zero.
//  Config      : `define HSRAM_STORE_BUFFER_EN adds a one-entry store buffer
//                that drains on the next port-free cycle and is merged into
//                loads that hit it. Without it, stores write the array
//                directly and a same-cycle load+store costs one extra stall.
//  Ports       : clk, rst_sync_n (sync, active-low)
//                access_ram_read/_raddr          - load request
//                access_ram_write/_waddr/_wdata  - store request (data right-justified)
//                access_ram_write_width          - 00 byte, 01 half, 10 word
//                access_ram_rdata                - word-aligned load data
//                core_stall_n                    - core advances this cycle
//                stall_req, bus_err              - stall request, error pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module hsbus_ram_responder
    import HSBus_Pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst_sync_n,
    input  logic        access_ram_read,
    input  logic        access_ram_write,
    input  logic [1:0]  access_ram_write_width,
    input  logic [31:0] access_ram_raddr,
    input  logic [31:0] access_ram_waddr,
    input  logic [31:0] access_ram_wdata,
    output logic [31:0] access_ram_rdata,
    input  logic        core_stall_n,
    output logic        stall_req,
    output logic        bus_err
);

    localparam int unsigned c_AW   = $clog2(DEPTH_WORDS);
    localparam logic [32:0] c_SPAN = 33'(DEPTH_WORDS) << 2;

    // ---------------------------------------------------------------- decode
    logic [31:0]     w_roff, w_woff;
    logic [c_AW-1:0] w_ridx, w_widx;
    logic            w_rin, w_win, w_st_ok;
    logic [3:0]      w_wbe;
    logic [31:0]     w_wlane;
    hs_width_e       w_width;

    assign w_width = hs_width_e'(access_ram_write_width);
    assign w_roff  = access_ram_raddr - BASE_ADDR;
    assign w_woff  = access_ram_waddr - BASE_ADDR;
    // Addresses below BASE_ADDR wrap to huge offsets and fail this test too.
    assign w_rin   = ({1'b0, w_roff} < c_SPAN);
    assign w_win   = ({1'b0, w_woff} < c_SPAN);
    assign w_ridx  = w_roff[c_AW+1:2];
    assign w_widx  = w_woff[c_AW+1:2];
    assign w_wbe   = hs_byte_en(w_width, access_ram_waddr[1:0]);
    assign w_wlane = hs_lane_data(w_width, access_ram_wdata);
    assign w_st_ok = w_win && !hs_misaligned(w_width, access_ram_waddr[1:0]);

    // --------------------------------------------------------------- control
    logic [1:0] state_q, state_d;
    logic       st_done_q, st_done_d;   // held store already applied
    logic       oor_q, oor_d;           // last issued load was out of range
    logic       bus_err_q, bus_err_d;
    logic       w_st_req, w_ld_req, w_collide;
    logic       w_stall, w_ld_issue, w_st_apply;

    // A store stays asserted while the core is stalled; st_done_q keeps it
    // from being applied (or flagged) a second time.
    assign w_st_req = rst_sync_n && access_ram_write && !st_done_q;
    assign w_ld_req = rst_sync_n && access_ram_read && (state_q == c_ST_IDLE);

    // ------------------------------------------------------ array port muxing
    logic            w_arr_rd, w_arr_wr;
    logic [c_AW-1:0] w_arr_idx;
    logic [3:0]      w_arr_be;
    logic [31:0]     w_arr_wdata, w_arr_rdata;

`ifdef HSRAM_STORE_BUFFER_EN
    logic            sb_valid_q;
    logic [c_AW-1:0] sb_idx_q;
    logic [31:0]     sb_data_q;
    logic [3:0]      sb_be_q;
    logic [31:0]     mg_data_q;
    logic [3:0]      mg_be_q;
    logic            w_drain, w_new_hit, w_old_hit;

    // Only a full buffer blocks a store that arrives with a load.
    assign w_collide  = w_st_req && sb_valid_q;
    assign w_drain    = rst_sync_n && sb_valid_q && !w_ld_issue;
    assign w_st_apply = w_st_req && (!sb_valid_q || w_drain);

    assign w_arr_rd    = w_ld_issue && w_rin;
    assign w_arr_wr    = w_drain;
    assign w_arr_idx   = w_ld_issue ? w_ridx : sb_idx_q;
    assign w_arr_be    = sb_be_q;
    assign w_arr_wdata = sb_data_q;

    // At load issue the buffer is either being filled by a same-cycle store
    // (which is ordered before the load) or holds an older store; never both.
    assign w_new_hit = w_st_apply && w_st_ok && (w_widx == w_ridx);
    assign w_old_hit = sb_valid_q && !w_drain && (sb_idx_q == w_ridx);

    always_ff @(posedge clk) begin
        if (!rst_sync_n) begin
            sb_valid_q <= 1'b0;
            sb_idx_q   <= '0;
            sb_data_q  <= '0;
            sb_be_q    <= '0;
            mg_data_q  <= '0;
            mg_be_q    <= '0;
        end else begin
            if (w_st_apply && w_st_ok) begin
                sb_valid_q <= 1'b1;
                sb_idx_q   <= w_widx;
                sb_data_q  <= w_wlane;
                sb_be_q    <= w_wbe;
            end else if (w_drain) begin
                sb_valid_q <= 1'b0;
            end
            if (w_ld_issue) begin
                if (w_new_hit) begin
                    mg_data_q <= w_wlane;
                    mg_be_q   <= w_wbe;
                end else if (w_old_hit) begin
                    mg_data_q <= sb_data_q;
                    mg_be_q   <= sb_be_q;
                end else begin
                    mg_be_q   <= 4'b0000;
                end
            end
        end
    end

    assign access_ram_rdata = oor_q ? 32'h0 :
        ((w_arr_rdata & ~hs_be_mask(mg_be_q)) | (mg_data_q & hs_be_mask(mg_be_q)));
`else
    // Any store arriving with a load takes the port first.
    assign w_collide  = w_st_req;
    assign w_st_apply = w_st_req && !w_ld_issue;

    assign w_arr_rd    = w_ld_issue && w_rin;
    assign w_arr_wr    = w_st_apply && w_st_ok;
    assign w_arr_idx   = w_ld_issue ? w_ridx : w_widx;
    assign w_arr_be    = w_wbe;
    assign w_arr_wdata = w_wlane;

    assign access_ram_rdata = oor_q ? 32'h0 : w_arr_rdata;
`endif

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!rst_sync_n) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_ld_req) begin
                    state_d = w_collide ? c_ST_RPEND : c_ST_RDATA;
                end
            end
            c_ST_RPEND: state_d = c_ST_RDATA;
            c_ST_RDATA: begin
                if (core_stall_n) begin
                    state_d = c_ST_IDLE;
                end
            end
            default: state_d = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_stall    = 1'b0;
        w_ld_issue = 1'b0;
        case (state_q)
            c_ST_IDLE: begin
                if (w_ld_req) begin
                    w_stall    = 1'b1;
                    w_ld_issue = !w_collide;
                end
            end
            c_ST_RPEND: begin
                w_stall    = 1'b1;
                w_ld_issue = 1'b1;
            end
            default: ;
        endcase
    end

    // ----------------------------------------------------- status registers
    assign st_done_d = core_stall_n ? 1'b0 : (st_done_q || w_st_apply);
    assign oor_d     = w_ld_issue ? !w_rin : oor_q;
    assign bus_err_d = (w_st_apply && !w_st_ok) || (w_ld_issue && !w_rin);

    always_ff @(posedge clk) begin
        if (!rst_sync_n) begin
            st_done_q <= 1'b0;
            oor_q     <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            st_done_q <= st_done_d;
            oor_q     <= oor_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign stall_req = w_stall;
    assign bus_err   = bus_err_q;

    HSRAM_Array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (c_AW)
    ) u_array (
        .clk        (clk),
        .rst_sync_n (rst_sync_n),
        .rd_en_i    (w_arr_rd),
        .wr_en_i    (w_arr_wr),
        .idx_i      (w_arr_idx),
        .wbe_i      (w_arr_be),
        .wdata_i    (w_arr_wdata),
        .rdata_o    (w_arr_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_hsbus_ram_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_hsbus_ram_responder
//  Description : Self-checking bench. The driver plays the core (its stall
//                input is the responder's stall_req plus an external stall),
//                pushes expected load results into a queue, and a monitor
//                pops/compares whenever load data is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hsbus_ram_responder;

    logic        clk = 1'b0;
    logic        rst_sync_n;
    logic        access_ram_read, access_ram_write;
    logic [1:0]  access_ram_write_width;
    logic [31:0] access_ram_raddr, access_ram_waddr, access_ram_wdata;
    logic [31:0] access_ram_rdata;
    logic        core_stall_n, stall_req, bus_err;
    logic        ext_stall;

    always #5 clk = ~clk;

    assign core_stall_n = !stall_req && !ext_stall;

    hsbus_ram_responder dut (
        .clk                    (clk),
        .rst_sync_n             (rst_sync_n),
        .access_ram_read        (access_ram_read),
        .access_ram_write       (access_ram_write),
        .access_ram_write_width (access_ram_write_width),
        .access_ram_raddr       (access_ram_raddr),
        .access_ram_waddr       (access_ram_waddr),
        .access_ram_wdata       (access_ram_wdata),
        .access_ram_rdata       (access_ram_rdata),
        .core_stall_n           (core_stall_n),
        .stall_req              (stall_req),
        .bus_err                (bus_err)
    );

`ifdef HSRAM_STORE_BUFFER_EN
    localparam int c_CMB_STALLS = 1;
`else
    localparam int c_CMB_STALLS = 2;
`endif

    typedef struct {
        logic [31:0] data;
        int          stalls;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   berr_seen = 0;
    int   exp_berr = 0;
    int   stall_cnt = 0;
    logic prev_berr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_sync_n) begin
                stall_cnt = 0;
                prev_berr = 1'b0;
            end else begin
                if (access_ram_read && stall_req) begin
                    stall_cnt++;
                end else if (access_ram_read) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rdata", 32'(exp_q.size()), 32'd1);
                    end else begin
                        chk("rdata", access_ram_rdata, exp_q[0].data);
                        if (core_stall_n) begin
                            chk("load_stalls", 32'(stall_cnt), 32'(exp_q[0].stalls));
                            void'(exp_q.pop_front());
                            stall_cnt = 0;
                        end
                    end
                end
                if (bus_err) begin
                    berr_seen++;
                    chk("berr_pulse_width", 32'(prev_berr), 32'd0);
                end
                prev_berr = bus_err;
            end
        end
    end

    // ----------------------------------------------------------------- driver
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_op(input string name, input bit rd, input bit wr,
                         input logic [31:0] ra, input logic [31:0] wa,
                         input logic [31:0] wd, input logic [1:0] ww,
                         input logic [31:0] exp_rd, input int exp_stalls,
                         input int hold, output int cycles);
        bit   done;
        int   left;
        exp_t e;
        done = 1'b0;
        left = hold;
        if (rd) begin
            e.data   = exp_rd;
            e.stalls = exp_stalls;
            exp_q.push_back(e);
        end
        access_ram_read        = rd;
        access_ram_write       = wr;
        access_ram_raddr       = ra;
        access_ram_waddr       = wa;
        access_ram_wdata       = wd;
        access_ram_write_width = ww;
        ext_stall              = 1'b0;
        cycles                 = 0;
        while (!done && cycles < 20) begin
            @(negedge clk);
            done = core_stall_n;
            @(posedge clk);
            #1;
            cycles++;
            if (!done && rd && !stall_req && left > 0) begin
                ext_stall = 1'b1;
                left--;
            end else begin
                ext_stall = 1'b0;
            end
        end
        chk({name, "_consumed"}, 32'(done), 32'd1);
        access_ram_read  = 1'b0;
        access_ram_write = 1'b0;
        ext_stall        = 1'b0;
    endtask

    task automatic st(input string name, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] w);
        int cyc;
        do_op(name, 1'b0, 1'b1, 32'h0, a, d, w, 32'h0, 0, 0, cyc);
        chk({name, "_cycles"}, 32'(cyc), 32'd1);
    endtask

    task automatic ld(input string name, input logic [31:0] a, input logic [31:0] exp,
                      input int hold);
        int cyc;
        do_op(name, 1'b1, 1'b0, a, 32'h0, 32'h0, 2'b10, exp, 1, hold, cyc);
    endtask

    task automatic berr_chk(input string name);
        idle(2);
        chk(name, 32'(berr_seen), 32'(exp_berr));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_sync_n             = 1'b0;
        access_ram_read        = 1'b0;
        access_ram_write       = 1'b0;
        access_ram_write_width = 2'b00;
        access_ram_raddr       = 32'h0;
        access_ram_waddr       = 32'h0;
        access_ram_wdata       = 32'h0;
        ext_stall              = 1'b0;
        idle(3);
        rst_sync_n = 1'b1;
        idle(1);
        chk("reset_stall_req", 32'(stall_req), 32'd0);
        chk("reset_bus_err", 32'(bus_err), 32'd0);
        chk("reset_rdata", access_ram_rdata, 32'h0);

        // word store then load back
        st("st_deadbeef", 32'h0001_0010, 32'hDEAD_BEEF, 2'b10);
        ld("ld_deadbeef", 32'h0001_0010, 32'hDEAD_BEEF, 0);

        // byte lane merge into existing word
        st("st_word", 32'h0001_0010, 32'h1122_3344, 2'b10);
        st("st_byte", 32'h0001_0013, 32'h0000_005A, 2'b00);
        ld("ld_byte_merge", 32'h0001_0010, 32'h5A22_3344, 0);

        // misaligned half: no write, one error pulse
        st("st_half_misal", 32'h0001_0011, 32'h0000_9999, 2'b01);
        exp_berr++;
        berr_chk("berr_half_misal");
        ld("ld_after_misal", 32'h0001_0010, 32'h5A22_3344, 0);

        // load below base: zero data, normal latency, error pulse
        ld("ld_oor_low", 32'h0000_0000, 32'h0, 0);
        exp_berr++;
        berr_chk("berr_ld_oor_low");

        // upper half store
        st("st_half_hi", 32'h0001_0012, 32'h0000_ABCD, 2'b01);
        ld("ld_half_hi", 32'h0001_0010, 32'hABCD_3344, 0);

        // reserved width
        st("st_rsvd", 32'h0001_0010, 32'hFFFF_FFFF, 2'b11);
        exp_berr++;
        berr_chk("berr_rsvd");
        ld("ld_after_rsvd", 32'h0001_0010, 32'hABCD_3344, 0);

        // last word in range, first word beyond
        st("st_last", 32'h0001_3FFC, 32'hA5A5_0F0F, 2'b10);
        ld("ld_last", 32'h0001_3FFC, 32'hA5A5_0F0F, 0);
        st("st_oor_high", 32'h0001_4000, 32'h1234_1234, 2'b10);
        exp_berr++;
        berr_chk("berr_st_oor_high");
        ld("ld_oor_high", 32'h0001_4000, 32'h0, 0);
        exp_berr++;
        berr_chk("berr_ld_oor_high");
        ld("ld_last_again", 32'h0001_3FFC, 32'hA5A5_0F0F, 0);

        // core stalls 3 cycles while load data is presented
        ld("ld_held", 32'h0001_0010, 32'hABCD_3344, 3);

        // same-cycle store and load to the same word
        do_op("ld_st_cafe", 1'b1, 1'b1, 32'h0001_0020, 32'h0001_0020, 32'hCAFE_0000,
              2'b10, 32'hCAFE_0000, c_CMB_STALLS, 0, cyc);
        idle(1);
        ld("ld_cafe", 32'h0001_0020, 32'hCAFE_0000, 0);

        // store immediately followed by load+byte store to that word
        st("st_b2b", 32'h0001_0030, 32'h1234_5678, 2'b10);
        do_op("ld_st_b2b", 1'b1, 1'b1, 32'h0001_0030, 32'h0001_0031, 32'h0000_00EE,
              2'b00, 32'h1234_EE78, 2, 0, cyc);
        idle(1);
        ld("ld_b2b", 32'h0001_0030, 32'h1234_EE78, 0);

        // reset while load data is presented
        access_ram_read  = 1'b1;
        access_ram_raddr = 32'h0001_0020;
        @(posedge clk);
        #1;
        rst_sync_n = 1'b0;
        @(posedge clk);
        #1;
        access_ram_read = 1'b0;
        rst_sync_n      = 1'b1;
        chk("midload_rst_stall_req", 32'(stall_req), 32'd0);
        chk("midload_rst_rdata", access_ram_rdata, 32'h0);
        chk("midload_rst_bus_err", 32'(bus_err), 32'd0);
        idle(1);
        ld("ld_after_rst", 32'h0001_0010, 32'hABCD_3344, 0);

        berr_chk("berr_total");
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hsbus_ram_responder.md
HSBUS_RAM_RESPONDER -- requirements
Module: hsbus_ram_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096, array depth in 32-bit words (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0001_0000, byte address of word 0 (DEPTH_WORDS*4 aligned).
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst_sync_n, input, 1, reset (synchronous, active-low).
REQ-005 SHALL have ports access_ram_read / access_ram_write, input, 1 each, load / store request from core.
REQ-006 SHALL have port access_ram_write_width, input, 2, 00 byte, 01 half, 10 word, 11 reserved.
REQ-007 SHALL have ports access_ram_raddr / access_ram_waddr / access_ram_wdata, input, 32 each.
REQ-008 SHALL have port access_ram_rdata, output, 32, word-aligned load data (core extracts lanes).
REQ-009 SHALL have port core_stall_n, input, 1, core advancing this cycle.
REQ-010 SHALL have port stall_req, output, 1, one bit of the core stall request vector.
REQ-011 SHALL have port bus_err, output, 1, one-cycle pulse on out-of-range or misaligned access.

Function
REQ-012 Array SHALL be single-ported; registered read, one access (read or write) per cycle.
REQ-013 Load FSM states IDLE, RDATA: IDLE + access_ram_read -> stall_req=1 combinationally, array read issued, -> RDATA.
REQ-014 In RDATA, stall_req SHALL be 0 and access_ram_rdata valid; return to IDLE only when core_stall_n=1, else hold rdata stable.
REQ-015 Load latency SHALL be exactly one stall cycle per load when no other stall source is active.
REQ-016 Byte enables: byte -> 1 lane at waddr[1:0]; half -> lanes {1:0} or {3:2}, waddr[0] must be 0; word -> all, waddr[1:0] must be 00.
REQ-017 Misaligned, reserved-width or out-of-range store SHALL write nothing and pulse bus_err.
REQ-018 Out-of-range load SHALL return 32'h0 with normal latency and pulse bus_err.
REQ-019 Stores SHALL complete without stall when the array port is free (core_stall_n=1 consumes the request exactly once).
REQ-020 A request held across core_stall_n=0 cycles SHALL be applied exactly once.
REQ-021 Address index SHALL be (addr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2]; no wrap beyond DEPTH_WORDS.

Reset
REQ-022 On rst_sync_n=0 at clk edge: FSM -> IDLE, stall_req=0, bus_err=0, access_ram_rdata=0, store buffer invalid; array contents not cleared.
REQ-023 Reset asserted mid-load or with buffered store SHALL discard the pending operation.

Configuration
REQ-024 Macro HSRAM_STORE_BUFFER_EN SHALL select a one-entry store buffer (addr, data, byte enables).
REQ-025 With macro: store captured into buffer at zero stall; buffer drains to array on next cycle without array read; load hitting buffered word SHALL return array word merged with buffered lanes; store arriving while buffer full and load in same cycle SHALL stall one cycle.
REQ-026 Without macro: stores write array directly; simultaneous load and store SHALL stall_req=1 for one extra cycle, store first, then load.

Structure
REQ-027 Package HSBus_Pkg SHALL hold width encoding enum, byte-enable function, and misalignment check function.
REQ-028 Sub-module HSRAM_Array SHALL implement the byte-enabled single-port word array with registered read.

Verification
REQ-029 Reset, then word store 32'hDEAD_BEEF at 32'h0001_0010, load same -> one stall cycle, rdata=32'hDEAD_BEEF.
REQ-030 Byte store 8'h5A at 32'h0001_0013 over 32'h1122_3344 -> load returns 32'h5A22_3344.
REQ-031 Half store at 32'h0001_0011 -> no array change, bus_err one-cycle pulse; load at 32'h0000_0000 -> rdata=0, bus_err pulse.
REQ-032 Load with core_stall_n held 0 for 3 cycles in RDATA -> rdata stable all 3 cycles, single array read.
REQ-033 Same-cycle store 32'hCAFE_0000 to 0x...20 and load of 0x...20 -> returns 32'hCAFE_0000 both configs (stall count 1 with macro, 2 without).
REQ-034 rst_sync_n low during RDATA -> next cycle stall_req=0, rdata=0, FSM IDLE.
